// File: rtl/ctrl_decode_lut_if.sv
// Lookup request / result handshake bundle for ctrl_decode_lut.
// The master side issues select codes and consumes decoded results.
// The slave side is the decoder itself.
interface ctrl_decode_lut_if #(
    parameter int SEL_W = 3,
    parameter int CH    = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic             out_valid;
    logic             out_ready;
    logic [CH-1:0]    out;
    logic             err;

    modport master (
        output in_valid,
        output sel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  err
    );

    modport slave (
        input  in_valid,
        input  sel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output err
    );
endinterface

// File: rtl/ctrl_decode_lut.sv
// Reloadable select-code to control-word decoder.
// Each entry of the lookup table carries a legality bit. Results are held
// in a one-entry output register behind a valid/ready handshake.
// Illegal lookups return zero, raise err, and bump a saturating counter.
module ctrl_decode_lut #(
    parameter int                          SEL_W       = 3,
    parameter int                          CH          = 4,
    parameter logic [CH*(2**SEL_W)-1:0]    RESET_TABLE = 32'h0001_0000,
    parameter logic [(2**SEL_W)-1:0]       RESET_VALID = 8'h7F,
    parameter int                          ERR_W       = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    ctrl_decode_lut_if.slave     bus,
    input  logic                 wr_en,
    input  logic [SEL_W-1:0]     wr_addr,
    input  logic [CH-1:0]        wr_data,
    input  logic                 wr_legal,
    input  logic                 err_clr,
    output logic [ERR_W-1:0]     err_cnt
);
    localparam int DEPTH = 2**SEL_W;

    logic [CH-1:0]    table_reg [DEPTH];
    logic             legal_reg [DEPTH];

    logic             out_valid_reg;
    logic [CH-1:0]    out_reg;
    logic             err_reg;
    logic [ERR_W-1:0] err_cnt_reg;

    logic             accept;
    logic             bypass_hit;
    logic [CH-1:0]    lookup_data;
    logic             lookup_legal;

    // The output register can take a new result when empty or being drained.
    assign bus.in_ready = !out_valid_reg || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // A write to the entry being looked up in the same cycle is forwarded.
    assign bypass_hit   = wr_en && (wr_addr == bus.sel);
    assign lookup_data  = bypass_hit ? wr_data  : table_reg[bus.sel];
    assign lookup_legal = bypass_hit ? wr_legal : legal_reg[bus.sel];

    // Table entries: each reloads its reset contents or takes a write.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (reset) begin
                    table_reg[gi] <= RESET_TABLE[gi*CH +: CH];
                    legal_reg[gi] <= RESET_VALID[gi];
                end else if (wr_en && (wr_addr == SEL_W'(gi))) begin
                    table_reg[gi] <= wr_data;
                    legal_reg[gi] <= wr_legal;
                end
            end
        end
    endgenerate

    // Output register: load on accept, drop valid when drained, hold otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            err_reg       <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_reg       <= lookup_legal ? lookup_data : '0;
            err_reg       <= !lookup_legal;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Saturating count of accepted illegal lookups; clear has priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_cnt_reg <= '0;
        end else if (err_clr) begin
            err_cnt_reg <= '0;
        end else if (accept && !lookup_legal && (err_cnt_reg != {ERR_W{1'b1}})) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out       = out_reg;
    assign bus.err       = err_reg;
    assign err_cnt       = err_cnt_reg;
endmodule

// File: doc/ctrl_decode_lut.md
# ctrl_decode_lut

Programmable, registered control-signal decoder that turns a SEL_W-bit select code into CH parallel control outputs. It replaces the fixed combinational select-to-flag decoders in the CPU control path. Each code maps through a reloadable lookup table with a per-entry legality bit. Lookups use a valid/ready handshake with a one-entry output register, and illegal codes are flagged and counted.

## Interface
- SEL_W, 3, width of the select code; the table has 2^SEL_W entries
- CH, 4, number of output control channels (bits per entry)
- RESET_TABLE, 32'h0001_0000, reset contents; entry i occupies bits [i*CH+CH-1 : i*CH]; the default sets channel 0 for code 3'b100 only
- RESET_VALID, 8'h7F, reset legality mask (bit i set means entry i is legal); the default makes code 3'b111 illegal
- ERR_W, 8, width of the error counter

Ports:
- Clock  in  1  sole clock; everything acts on its rising edge
- Reset  in  1  synchronous, active-high
- InValid  in  1  a lookup request is present
- InReady  out  1  block can accept a request; equals !OutValid || OutReady (combinational)
- Sel  in  SEL_W  select code, sampled on accept
- OutValid  out  1  Out/Err hold a result
- OutReady  in  1  consumer takes the result
- Out  out  CH  decoded control word
- Err  out  1  result came from an illegal code
- WrEn  in  1  table write strobe, always accepted
- WrAddr  in  SEL_W  entry to write
- WrData  in  CH  new entry contents
- WrLegal  in  1  new legality bit for the entry
- ErrClr  in  1  clear the error counter
- ErrCnt  out  ERR_W  saturating count of accepted illegal lookups

## Operation
- Reset (any cycle, including mid-transfer):
  - table loads RESET_TABLE; legality loads RESET_VALID
  - OutValid=0, Out=0, Err=0, ErrCnt=0
  - a pending result is discarded
  - WrEn and InValid are ignored in the reset cycle
- Accept: a request is accepted when InValid && InReady.
  - Next cycle: OutValid=1.
  - If the entry is legal: Out=table[Sel], Err=0.
  - If the entry is illegal: Out=0, Err=1.
- Write/lookup collision: if WrEn is high and WrAddr==Sel in the accept cycle, the lookup returns WrData/WrLegal (write-first bypass). The table also updates in that cycle.
- Hold: while OutValid && !OutReady, Out, Err and OutValid stay stable and InReady=0.
- Drain: when OutValid && OutReady && !(InValid && InReady), OutValid goes 0 next cycle. Out and Err keep their last values (don't-care).
- Back-to-back: with OutValid && OutReady && InValid, InReady=1. The new result replaces the old one the next cycle, so full throughput is one lookup per cycle.
- Writes: on WrEn, entry WrAddr takes WrData and WrLegal at the clock edge.
  - Writes never stall.
  - Writes do not change a result already held in the output register.
- ErrCnt:
  - increments by 1 on each accepted illegal lookup
  - saturates at 2^ERR_W-1
  - ErrClr forces it to 0 next cycle; ErrClr wins over a same-cycle increment

## Timing
- Lookup latency: 1 cycle, from the accept edge to OutValid.
- Write-to-lookup: a lookup accepted in the cycle after a write sees the new entry. A lookup in the same cycle also sees it, through the bypass.
- InReady is combinational from OutValid and OutReady; there is no combinational path from Sel or InValid to any output.
- ErrCnt updates in the same cycle that OutValid/Err are registered for the illegal result.

## Test plan
- Reset defaults: deassert Reset, then lookup Sel=4 -> next cycle OutValid=1, Out=4'b0001, Err=0. Lookup Sel=2 -> Out=4'b0000, Err=0.
- Illegal code: lookup Sel=7 -> Out=0, Err=1, ErrCnt=1. Then 300 consecutive illegal lookups -> ErrCnt=255. ErrClr together with an illegal accept -> ErrCnt=0.
- Backpressure: hold OutReady=0 for 5 cycles with InValid=1 and changing Sel -> InReady=0, and Out stays at the first result. Raise OutReady -> the next request is accepted and its result appears one cycle later.
- Same-cycle bypass: WrEn=1, WrAddr=3, WrData=4'b1010, WrLegal=1 together with an accepted lookup Sel=3 -> Out=4'b1010, Err=0. Then write WrAddr=3, WrLegal=0 and look up Sel=3 -> Err=1, Out=0.
- Throughput: OutReady=1, InValid=1 for 8 cycles with Sel=0..7 -> 8 results on 8 consecutive cycles, in order, Err set only for Sel=7.
- Reset mid-operation: OutValid=1 and OutReady=0 with entry 4 rewritten to 4'b1111; assert Reset for 1 cycle -> OutValid=0, ErrCnt=0. A following lookup of Sel=4 returns 4'b0001.
